// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions.
// Widths, data-memory responder FSM type, lane merge helper.
package riscv_defines;

  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  // Replace the bytes selected by we; we[3] is the [31:24] lane.
  function automatic logic [RISCV_WORD_WIDTH-1:0] lane_merge(
    input logic [RISCV_WORD_WIDTH-1:0] old_w,
    input logic [RISCV_WORD_WIDTH-1:0] new_w,
    input logic [3:0]                  we
  );
    logic [RISCV_WORD_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enable word RAM with a registered read port.
// The read port returns the post-write word on a write.
module dmem_ram
  import riscv_defines::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [AW-1:0]               addr,
  input  logic [3:0]                  we,
  input  logic [RISCV_WORD_WIDTH-1:0] wdata,
  output logic [RISCV_WORD_WIDTH-1:0] q
);

  logic [RISCV_WORD_WIDTH-1:0] mem [WORDS];
  logic [RISCV_WORD_WIDTH-1:0] word;

  assign word = lane_merge(mem[addr], wdata, we);

  // Storage: per-lane write, contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: held between accesses, zeroed on a rejected one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= word;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: captures a request, waits, answers once.
// Out-of-range requests are answered with err_o and zero data.
module dmem_responder
  import riscv_defines::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dmem_valid_i,
  output logic                        dmem_ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]                  dmem_we_i,
  output logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_o,
  output logic                        err_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dmem_resp_state_t state;
  dmem_resp_state_t state_nxt;

  logic [CW-1:0]               cnt;
  logic [RISCV_ADDR_WIDTH-1:0] addr_q;
  logic [RISCV_WORD_WIDTH-1:0] wdata_q;
  logic [3:0]                  we_q;

  logic [RISCV_ADDR_WIDTH-1:0] a_sel;
  logic [RISCV_WORD_WIDTH-1:0] wd_sel;
  logic [3:0]                  we_sel;
  logic [RISCV_ADDR_WIDTH-1:0] off;
  logic [RISCV_ADDR_WIDTH-1:0] idx;
  logic                        in_range;
  logic                        access;
  logic                        accept;
  logic                        ram_en;
  logic                        ram_clr;

  assign accept = (state == IDLE) && dmem_valid_i;

  // With no wait the access shares the accepting edge,
  // so the request is taken straight from the inputs.
  assign a_sel  = (state == IDLE) ? dmem_addr_i  : addr_q;
  assign wd_sel = (state == IDLE) ? dmem_wdata_i : wdata_q;
  assign we_sel = (state == IDLE) ? dmem_we_i    : we_q;

  assign off = a_sel - BASE_ADDR;
  assign idx = off >> 2;
  assign in_range = (a_sel >= BASE_ADDR) &&
                    (idx < RISCV_ADDR_WIDTH'(MEM_WORDS));

  // Next state and the edge that performs the access.
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmem_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // No memory side effect may slip through while reset is held.
  assign ram_en  = rst_n && access && in_range;
  assign ram_clr = rst_n && access && !in_range;

  // FSM, wait counter and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem_ready_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      dmem_ready_o <= access;
      err_o        <= access && !in_range;
      if (accept) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
    end else if (accept) begin
      addr_q  <= dmem_addr_i;
      wdata_q <= dmem_wdata_i;
      we_q    <= dmem_we_i;
    end
  end

  dmem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .clr   (ram_clr),
    .addr  (idx[AW-1:0]),
    .we    (we_sel),
    .wdata (wd_sel),
    .q     (dmem_rdata_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Three instances cover wait depths 0, 1 and 3.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;

  logic        r0, r1, r3;
  logic        e0, e1, e3;
  logic [31:0] d0, d1, d3;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  dmem_responder #(
    .MEM_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)
  ) u_w1 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid),
    .dmem_ready_o(r1), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we),
    .dmem_rdata_o(d1), .err_o(e1)
  );

  dmem_responder #(
    .MEM_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
  ) u_w0 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid),
    .dmem_ready_o(r0), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we),
    .dmem_rdata_o(d0), .err_o(e0)
  );

  dmem_responder #(
    .MEM_WORDS(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)
  ) u_w3 (
    .clk(clk), .rst_n(rst_n), .dmem_valid_i(valid),
    .dmem_ready_o(r3), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we),
    .dmem_rdata_o(d3), .err_o(e3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Issue one request to the WAIT_CYCLES=1 instance.
  task automatic do_req(input logic [31:0] a,
                        input logic [3:0] w,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    @(negedge clk);
    addr  = a;
    we    = w;
    wdata = wd;
    valid = 1'b1;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (i == 0) valid = 1'b0;
      if (r1) begin
        rd = d1;
        er = e1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("ready_one_cycle", {31'b0, r1}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          f0, f1, f3, c0, c1, c3;
    int          p1, p2, np;

    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{32'h10, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{32'h10, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h10, 4'b1111, 32'h11223344, 32'h11223344, 1'b0};
    vecs[3]  = '{32'h10, 4'b0100, 32'h00AA0000, 32'h11AA3344, 1'b0};
    vecs[4]  = '{32'h10, 4'b0000, 32'h0,        32'h11AA3344, 1'b0};
    vecs[5]  = '{32'h0,  4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{32'h1000, 4'b1111, 32'h12345678, 32'h0,      1'b1};
    vecs[7]  = '{32'h0,  4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[8]  = '{32'hFFC, 4'b1111, 32'h0A0B0C0D, 32'h0A0B0C0D, 1'b0};
    vecs[9]  = '{32'h13, 4'b0000, 32'h0,        32'h11AA3344, 1'b0};
    vecs[10] = '{32'hFFFFFFFC, 4'b0000, 32'h0,  32'h0,        1'b1};
    vecs[11] = '{32'h20, 4'b1111, 32'h55667788, 32'h55667788, 1'b0};

    rst_n = 1'b0;
    valid = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, r1}, 32'd0);
    check("rst_err",   {31'b0, e1}, 32'd0);
    check("rst_rdata", d1, 32'h0);
    check("rst_rdata_w3", d3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].addr, vecs[i].we, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_err", i), {31'b0, er},
            {31'b0, vecs[i].err});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    end

    repeat (10) @(posedge clk);

    // All three depths accept on the same edge.
    f0 = 0; f1 = 0; f3 = 0;
    c0 = 0; c1 = 0; c3 = 0;
    @(negedge clk);
    addr  = 32'h40;
    we    = 4'b1111;
    wdata = 32'h01020304;
    valid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) valid = 1'b0;
      if (r0) begin if (f0 == 0) f0 = e; c0++; end
      if (r1) begin if (f1 == 0) f1 = e; c1++; end
      if (r3) begin if (f3 == 0) f3 = e; c3++; end
    end
    check("lat_w0", 32'(f0), 32'd1);
    check("lat_w1", 32'(f1), 32'd2);
    check("lat_w3", 32'(f3), 32'd4);
    check("pulses_w0", 32'(c0), 32'd1);
    check("pulses_w1", 32'(c1), 32'd1);
    check("pulses_w3", 32'(c3), 32'd1);
    check("hold_rdata_w0", d0, 32'h01020304);
    check("hold_rdata_w1", d1, 32'h01020304);
    check("hold_rdata_w3", d3, 32'h01020304);

    repeat (10) @(posedge clk);

    // Valid held high through RESP: second transfer waits for IDLE.
    p1 = 0; p2 = 0; np = 0;
    @(negedge clk);
    addr  = 32'h10;
    we    = 4'b0000;
    wdata = 32'h0;
    valid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (r1) begin
        np++;
        if (p1 == 0) p1 = e;
        else if (p2 == 0) p2 = e;
        if (np == 2) valid = 1'b0;
      end
    end
    valid = 1'b0;
    check("b2b_first", 32'(p1), 32'd2);
    check("b2b_second", 32'(p2), 32'd5);
    check("b2b_count", 32'(np), 32'd2);
    check("b2b_rdata", d1, 32'h11AA3344);

    repeat (10) @(posedge clk);

    // Reset while a write to 0x20 sits in WAIT.
    np = 0;
    @(negedge clk);
    addr  = 32'h20;
    we    = 4'b1111;
    wdata = 32'hBAD0BAD0;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (r1) np++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_rdata", d1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (r1) np++;
    end
    check("rst_no_ready", 32'(np), 32'd0);
    do_req(32'h20, 4'b0000, 32'h0, rd, er, lat);
    check("rst_old_value", rd, 32'h55667788);
    check("rst_old_err", {31'b0, er}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
